// File: rtl/mem_wb_return_path.sv
// mem_wb_return_path: EX/MEM and MEM/WB registers, data memory, branch resolution and writeback return path
module mem_wb_return_path #(
  parameter int DMEM_WORDS = 1024,
  parameter int DMEM_AW    = 10
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadData2,
  input  logic [31:0] ReadDataHi,
  input  logic [31:0] ReadDataLo,
  input  logic [31:0] BranchTarget,
  input  logic        Zero,
  input  logic [4:0]  WriteRegisterIn,
  input  logic        RegWriteIn,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic        MemToReg,
  input  logic        HiLoToReg,
  input  logic        HiOrLo,
  input  logic        Branch,
  input  logic        MoveNotZero,
  input  logic        DontMove,
  input  logic        Flush,
  output logic        BranchTaken,
  output logic [31:0] BranchAddress,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  output logic        Move
);
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] read_data2;
    logic [31:0] read_data_hi;
    logic [31:0] read_data_lo;
    logic [31:0] branch_target;
    logic        zero;
    logic [4:0]  write_register;
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic        mem_to_reg;
    logic        hilo_to_reg;
    logic        hi_or_lo;
    logic        branch;
    logic        move_not_zero;
    logic        dont_move;
  } m_t;
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [31:0] hilo;
    logic [4:0]  write_register;
    logic        reg_write;
    logic        move;
    logic        mem_to_reg;
    logic        hilo_to_reg;
  } w_t;
  m_t m_d, m_q;
  w_t w_d, w_q;
  logic [31:0]        dmem [DMEM_WORDS];
  logic [DMEM_AW-1:0] idx;
  logic               move_ok;
  assign idx     = m_q.alu_result[DMEM_AW+1:2];
  assign move_ok = m_q.dont_move | (m_q.move_not_zero ? |m_q.read_data2 : ~|m_q.read_data2);
  // a flush turns the captured instruction into a bubble but keeps its data fields
  always_comb begin
    m_d = '{
      alu_result:     ALUResult,
      read_data2:     ReadData2,
      read_data_hi:   ReadDataHi,
      read_data_lo:   ReadDataLo,
      branch_target:  BranchTarget,
      zero:           Zero,
      write_register: WriteRegisterIn,
      reg_write:      RegWriteIn & ~Flush,
      mem_write:      MemWrite & ~Flush,
      mem_read:       MemRead & ~Flush,
      mem_to_reg:     MemToReg & ~Flush,
      hilo_to_reg:    HiLoToReg & ~Flush,
      hi_or_lo:       HiOrLo & ~Flush,
      branch:         Branch & ~Flush,
      move_not_zero:  MoveNotZero & ~Flush,
      dont_move:      DontMove & ~Flush
    };
  end
  always_comb begin
    w_d = '{
      alu_result:     m_q.alu_result,
      mem_data:       m_q.mem_read ? dmem[idx] : 32'h0,
      hilo:           m_q.hi_or_lo ? m_q.read_data_hi : m_q.read_data_lo,
      write_register: m_q.write_register,
      reg_write:      m_q.reg_write & move_ok,
      move:           m_q.reg_write & ~m_q.dont_move & move_ok,
      mem_to_reg:     m_q.mem_to_reg,
      hilo_to_reg:    m_q.hilo_to_reg
    };
  end
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_q <= '0;
      w_q <= '0;
    end else begin
      m_q <= m_d;
      w_q <= w_d;
    end
  end
  always_ff @(posedge Clk) begin
    if (Rst && m_q.mem_write) dmem[idx] <= m_q.read_data2;
  end
  assign BranchTaken   = m_q.branch & m_q.zero;
  assign BranchAddress = m_q.branch_target;
  assign WriteRegister = w_q.write_register;
  assign WriteData     = w_q.hilo_to_reg ? w_q.hilo : (w_q.mem_to_reg ? w_q.mem_data : w_q.alu_result);
  assign RegWrite      = w_q.reg_write & |w_q.write_register;
  assign Move          = w_q.move;
endmodule

// File: doc/mem_wb_return_path.md
# mem_wb_return_path

Back end of the five-stage MIPS pipeline: holds the EX/MEM and MEM/WB pipeline registers, the data memory, and branch resolution. It consumes the Execute stage outputs and drives the two return paths into the front of the pipe. The register-write triple (WriteRegister/WriteData/RegWrite plus Move) goes back to InstructionDecode. The taken-branch request (Branch/BranchAddress) goes back to InstructionFetchUnit.

## Interface
Parameters:
- DMEM_WORDS, 1024: data memory depth in 32-bit words (power of two)
- DMEM_AW, 10: log2(DMEM_WORDS)

Ports:
- Clk  in  1  pipeline clock, rising edge
- Rst  in  1  reset; one clock; reset is asynchronous and active-low
- ALUResult  in  32  EX ALU result / memory byte address
- ReadData2  in  32  rt value: store data and move-condition operand
- ReadDataHi, ReadDataLo  in  32 each  HI/LO register values from EX
- BranchTarget  in  32  computed branch target from EX
- Zero  in  1  ALU zero flag
- WriteRegisterIn  in  5  destination register from EX
- RegWriteIn, MemWrite, MemRead, MemToReg, HiLoToReg, HiOrLo, Branch, MoveNotZero, DontMove  in  1 each  EX control bits
- Flush  in  1  load a bubble into EX/MEM at this edge
- BranchTaken  out  1  to IF: redirect PC
- BranchAddress  out  32  to IF: redirect target
- WriteRegister  out  5  to ID register file
- WriteData  out  32  to ID register file
- RegWrite  out  1  to ID: qualified write enable
- Move  out  1  to ID: write came from a conditional move that passed

## Operation
- EX/MEM register (M stage) captures all inputs every rising edge. If Flush=1, all control bits are loaded as 0 and data fields load normally.
- Data memory: word index = ALUResult_M[DMEM_AW+1:2]. Address bits [1:0] are ignored. Upper bits beyond the index are ignored, so addresses wrap modulo DMEM_WORDS.
  - Write: synchronous at the rising edge when MemWrite_M=1.
  - Read: combinational. Read data is only meaningful when MemRead_M=1, otherwise don't-care.
  - Memory is not reset.
- Branch resolution in M: BranchTaken = Branch_M & Zero_M. BranchAddress = BranchTarget_M, driven every cycle.
- Move qualification in M: MoveOK = DontMove_M | (MoveNotZero_M ? (ReadData2_M != 0) : (ReadData2_M == 0)).
- MEM/WB register (W stage) captures on every edge:
  - RegWrite_W = RegWriteIn_M & MoveOK
  - Move_W = RegWriteIn_M & ~DontMove_M & MoveOK
  - WriteRegister_M, ALUResult_M, memory read data, HiLo_M = HiOrLo_M ? ReadDataHi_M : ReadDataLo_M, MemToReg_M, HiLoToReg_M
- Writeback mux (combinational from the W register): WriteData = HiLoToReg_W ? HiLo_W : (MemToReg_W ? MemData_W : ALUResult_W). HiLoToReg has priority over MemToReg.
- RegWrite is forced to 0 when WriteRegister_W == 0.

## Timing
- Reset (Rst=0, asynchronous): every EX/MEM and MEM/WB field clears to 0. Outputs then read: BranchTaken=0, BranchAddress=0, WriteRegister=0, WriteData=0, RegWrite=0, Move=0. Release is synchronous to the next edge.
- Reset asserted mid-operation drops any in-flight write or branch immediately. A store in M is not committed if Rst is low at its edge.
- Latency is counted from the edge that captures EX outputs (edge N):
  - BranchTaken/BranchAddress valid in the cycle after edge N.
  - Store commits at edge N+1.
  - WriteRegister/WriteData/RegWrite valid in the cycle after edge N+1, held one cycle.
- A store followed directly by a load to the same word returns the new data, because the write commits at the edge that brings the load into M.
- Flush and Branch on the same edge: Flush wins, and BranchTaken stays 0 the following cycle.
- The block never stalls. Throughput is one instruction per clock.

## Test plan
- Reset: hold Rst=0 with random inputs -> all six outputs read 0. Release, drive RegWriteIn=1, DontMove=1, WriteRegisterIn=5, ALUResult=0x1234 -> two cycles later RegWrite=1, WriteRegister=5, WriteData=0x1234, Move=0.
- Store/load: store 0xDEADBEEF at ALUResult=0x10, then next cycle load from 0x13 with MemToReg=1, WriteRegisterIn=8 -> WriteData=0xDEADBEEF. Load from 0x1010 (DMEM_WORDS=1024) -> same word, showing wrap-around.
- Branch: Branch=1, Zero=1, BranchTarget=0x40 -> BranchTaken=1, BranchAddress=0x40 one cycle later. Repeat with Zero=0 -> BranchTaken=0. Repeat with Zero=1 and Flush=1 -> BranchTaken=0.
- Conditional moves:
  - movn (MoveNotZero=1, DontMove=0), ReadData2=7 -> RegWrite=1, Move=1.
  - movn with ReadData2=0 -> RegWrite=0.
  - movz with ReadData2=0 -> RegWrite=1, Move=1.
- HI/LO: HiLoToReg=1, MemToReg=1, HiOrLo=1, ReadDataHi=0xAAAA0000 -> WriteData=0xAAAA0000. With HiOrLo=0 and ReadDataLo=0x5555 -> WriteData=0x5555. Also WriteRegisterIn=0 with RegWriteIn=1 -> RegWrite=0.
- Mid-stream reset: assert Rst=0 asynchronously while a store to 0x20 sits in M -> memory word 0x20 unchanged and outputs cleared before the next edge.
